// File: rtl/mul_ctrl.sv
// Sequencer between an issue port and an external multiplier: classifies the
// op, reuses a one-entry result cache, and returns the selected product half.
module mul_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [2:0]  op_funct3,
  input  logic        op_w,
  input  logic [63:0] op_src1,
  input  logic [63:0] op_src2,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [63:0] res_data,
  input  logic        flush,
  output logic        mul_valid,
  input  logic        mul_ready,
  output logic        mul_flush,
  output logic        mulw,
  output logic [1:0]  mul_signed,
  output logic [63:0] multiplicand,
  output logic [63:0] multiplier,
  input  logic        mul_out_valid,
  input  logic [63:0] mul_result_hi,
  input  logic [63:0] mul_result_lo
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      state_q;
  logic        mul_valid_q;
  logic        res_valid_q;
  logic [63:0] res_data_q;
  logic        mulw_q;
  logic [1:0]  mul_signed_q;
  logic [2:0]  funct3_q;
  logic [63:0] multiplicand_q;
  logic [63:0] multiplier_q;

  logic        cache_vld_q;
  logic [63:0] cache_mcand_q;
  logic [63:0] cache_mplier_q;
  logic [1:0]  cache_sgn_q;
  logic        cache_w_q;
  logic [63:0] cache_hi_q;
  logic [63:0] cache_lo_q;

  logic [1:0]  mode_s;
  logic        hit_s;
  logic        accept_s;

  // Word ops always run signed x signed; only the low 32 bits are kept.
  function automatic logic [1:0] mode_of(input logic [2:0] f3, input logic w);
    logic [1:0] m;
    if (w) begin
      m = 2'b11;
    end else begin
      case (f3)
        3'b010:  m = 2'b10;
        3'b011:  m = 2'b00;
        default: m = 2'b11;
      endcase
    end
    return m;
  endfunction

  function automatic logic [63:0] select_result(input logic [2:0]  f3,
                                                input logic        w,
                                                input logic [63:0] hi,
                                                input logic [63:0] lo);
    logic [63:0] r;
    if (w) begin
      r = {{32{lo[31]}}, lo[31:0]};
    end else begin
      case (f3)
        3'b001, 3'b010, 3'b011: r = hi;
        default:                r = lo;
      endcase
    end
    return r;
  endfunction

  assign mode_s   = mode_of(op_funct3, op_w);
  assign hit_s    = cache_vld_q
                 && (cache_mcand_q  == op_src1)
                 && (cache_mplier_q == op_src2)
                 && (cache_sgn_q    == mode_s)
                 && (cache_w_q      == op_w);
  assign op_ready = (state_q == S_IDLE) && !rst && !flush;
  assign accept_s = op_valid && op_ready;
  assign mul_flush = flush && !rst && ((state_q == S_ISSUE) || (state_q == S_WAIT));

  assign mul_valid    = mul_valid_q;
  assign res_valid    = res_valid_q;
  assign res_data     = res_data_q;
  assign mulw         = mulw_q;
  assign mul_signed   = mul_signed_q;
  assign multiplicand = multiplicand_q;
  assign multiplier   = multiplier_q;

  // Control FSM with its registered outputs and the result cache.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      mul_valid_q    <= 1'b0;
      res_valid_q    <= 1'b0;
      res_data_q     <= 64'd0;
      mulw_q         <= 1'b0;
      mul_signed_q   <= 2'b00;
      funct3_q       <= 3'b000;
      multiplicand_q <= 64'd0;
      multiplier_q   <= 64'd0;
      cache_vld_q    <= 1'b0;
      cache_mcand_q  <= 64'd0;
      cache_mplier_q <= 64'd0;
      cache_sgn_q    <= 2'b00;
      cache_w_q      <= 1'b0;
      cache_hi_q     <= 64'd0;
      cache_lo_q     <= 64'd0;
    end else if (flush) begin
      // Kill wins over any handshake in this cycle; the cache is retained.
      state_q     <= S_IDLE;
      mul_valid_q <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept_s) begin
            multiplicand_q <= op_src1;
            multiplier_q   <= op_src2;
            funct3_q       <= op_funct3;
            mulw_q         <= op_w;
            mul_signed_q   <= mode_s;
            if (hit_s) begin
              state_q     <= S_DONE;
              res_valid_q <= 1'b1;
              res_data_q  <= select_result(op_funct3, op_w, cache_hi_q, cache_lo_q);
            end else begin
              state_q     <= S_ISSUE;
              mul_valid_q <= 1'b1;
            end
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_ISSUE: begin
          if (mul_ready) begin
            state_q     <= S_WAIT;
            mul_valid_q <= 1'b0;
          end else begin
            state_q <= S_ISSUE;
          end
        end
        S_WAIT: begin
          if (mul_out_valid) begin
            cache_vld_q    <= 1'b1;
            cache_mcand_q  <= multiplicand_q;
            cache_mplier_q <= multiplier_q;
            cache_sgn_q    <= mul_signed_q;
            cache_w_q      <= mulw_q;
            cache_hi_q     <= mul_result_hi;
            cache_lo_q     <= mul_result_lo;
            res_data_q     <= select_result(funct3_q, mulw_q, mul_result_hi, mul_result_lo);
            res_valid_q    <= 1'b1;
            state_q        <= S_DONE;
          end else begin
            state_q <= S_WAIT;
          end
        end
        S_DONE: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end else begin
            state_q <= S_DONE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          mul_valid_q <= 1'b0;
          res_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
